// File: rtl/conv_stream_ctrl.sv
// Frame controller for a 2x2 streaming convolution datapath: buffers one image,
// loads the kernel, replays the pixels gap-free and queues results for downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// Upstream pix_valid may toggle freely; pix_ready depends only on state. Downstream
// res_valid never drops and res_data/res_last never change until the word is taken.
module conv_stream_ctrl #(
    parameter int dataSize  = 8,
    parameter int IMG_WIDTH = 3,
    parameter int TIMEOUT   = 64,
    localparam int NPIX  = IMG_WIDTH * IMG_WIDTH,
    localparam int NRES  = (IMG_WIDTH - 1) * (IMG_WIDTH - 1),
    localparam int RES_W = 2 * dataSize + 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [dataSize-1:0] cfg_w1,
    input  logic [dataSize-1:0] cfg_w2,
    input  logic [dataSize-1:0] cfg_w3,
    input  logic [dataSize-1:0] cfg_w4,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [dataSize-1:0] pix_data,
    output logic [dataSize-1:0] dp_pixel,
    output logic [dataSize-1:0] dp_w1,
    output logic [dataSize-1:0] dp_w2,
    output logic [dataSize-1:0] dp_w3,
    output logic [dataSize-1:0] dp_w4,
    output logic                dp_kernel_load_valid,
    input  logic                dp_window_valid,
    input  logic [RES_W-1:0]    dp_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RES_W-1:0]    res_data,
    output logic                res_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        KLOAD  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        FLUSH  = 3'd5
    } state_t;

    localparam int PIX_CW = $clog2(NPIX + 1);
    localparam int PIX_IW = $clog2(NPIX);
    localparam int RES_CW = $clog2(NRES + 1);
    localparam int PTR_W  = (NRES > 1) ? $clog2(NRES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t state, state_nxt;

    logic [PIX_CW-1:0]   wr_cnt;
    logic [PIX_CW-1:0]   rd_cnt;
    logic [RES_CW-1:0]   res_cnt;
    logic [TO_W-1:0]     drain_cnt;
    logic [dataSize-1:0] pix_buf [NPIX];

    logic [RES_W-1:0]    fifo_data [NRES];
    logic                fifo_last [NRES];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [RES_CW-1:0]   fifo_cnt;

    logic start_acc;
    logic pix_xfer;
    logic in_collect;
    logic res_full;
    logic fifo_full;
    logic push;
    logic pop;
    logic drop;
    logic timeout_hit;
    logic fill_last;
    logic stream_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NRES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_acc   = (state == IDLE) && start;
    assign pix_xfer    = pix_valid && pix_ready;
    assign in_collect  = (state == STREAM) || (state == DRAIN);
    assign res_full    = (res_cnt == RES_CW'(NRES));
    assign fifo_full   = (fifo_cnt == RES_CW'(NRES));
    assign pop         = res_valid && res_ready;
    assign fill_last   = pix_xfer && (wr_cnt == PIX_CW'(NPIX - 1));
    assign stream_last = (rd_cnt == PIX_CW'(NPIX - 1));

    // A strobe is only accepted while a frame is collecting and still owes results;
    // anything else is a protocol violation by the datapath and is flagged.
    assign push = dp_window_valid && in_collect && !res_full && (!fifo_full || pop);
    assign drop = dp_window_valid && !push;

    assign timeout_hit = (state == DRAIN) && !res_full &&
                         (drain_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (fill_last) state_nxt = KLOAD;
            KLOAD:   state_nxt = STREAM;
            STREAM:  if (stream_last) state_nxt = DRAIN;
            DRAIN:   if (res_full || timeout_hit) state_nxt = FLUSH;
            FLUSH:   if (fifo_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pix_ready            = (state == FILL);
    assign dp_kernel_load_valid = (state == KLOAD);
    assign dp_pixel             = (state == STREAM) ? pix_buf[rd_cnt[PIX_IW-1:0]] : '0;
    assign busy                 = (state != IDLE);
    assign done                 = (state == FLUSH) && (fifo_cnt == '0);
    assign res_valid            = (fifo_cnt != '0);
    assign res_data             = res_valid ? fifo_data[rd_ptr] : '0;
    assign res_last             = res_valid && fifo_last[rd_ptr];
    assign state_dbg            = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            res_cnt   <= '0;
            drain_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            err       <= 1'b0;
            dp_w1     <= '0;
            dp_w2     <= '0;
            dp_w3     <= '0;
            dp_w4     <= '0;
        end else begin
            state <= state_nxt;

            if (start_acc) begin
                dp_w1   <= cfg_w1;
                dp_w2   <= cfg_w2;
                dp_w3   <= cfg_w3;
                dp_w4   <= cfg_w4;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                res_cnt <= '0;
            end else if (push) begin
                res_cnt <= res_cnt + 1'b1;
            end

            if (pix_xfer) begin
                wr_cnt <= fill_last ? '0 : wr_cnt + 1'b1;
            end

            if (state == STREAM) begin
                rd_cnt <= stream_last ? '0 : rd_cnt + 1'b1;
            end

            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            // A fault in the same cycle as an accepted start still belongs on record.
            if (drop || timeout_hit) begin
                err <= 1'b1;
            end else if (start_acc) begin
                err <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; pointers and counters qualify every read.
    always_ff @(posedge clk) begin
        if (pix_xfer) begin
            pix_buf[wr_cnt[PIX_IW-1:0]] <= pix_data;
        end
        if (push) begin
            fifo_data[wr_ptr] <= dp_result;
            fifo_last[wr_ptr] <= (res_cnt == RES_CW'(NRES - 1));
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl: a behavioural 2x2 datapath model feeds
// results back, a frame table covers nominal traffic, hand sequences cover corners.
module tb_conv_stream_ctrl;

    localparam int DW    = 8;
    localparam int RES_W = 2 * DW + 5;
    localparam int NPIX  = 9;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_KLOAD  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [DW-1:0]    cfg_w1 = '0, cfg_w2 = '0, cfg_w3 = '0, cfg_w4 = '0;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [DW-1:0]    pix_data = '0;
    logic [DW-1:0]    dp_pixel;
    logic [DW-1:0]    dp_w1, dp_w2, dp_w3, dp_w4;
    logic             dp_kernel_load_valid;
    logic             dp_window_valid = 1'b0;
    logic [RES_W-1:0] dp_result = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [RES_W-1:0] res_data;
    logic             res_last;
    logic             busy, done, err;
    logic [2:0]       state_dbg;

    conv_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_w1(cfg_w1), .cfg_w2(cfg_w2), .cfg_w3(cfg_w3), .cfg_w4(cfg_w4),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .dp_pixel(dp_pixel), .dp_w1(dp_w1), .dp_w2(dp_w2), .dp_w3(dp_w3), .dp_w4(dp_w4),
        .dp_kernel_load_valid(dp_kernel_load_valid),
        .dp_window_valid(dp_window_valid), .dp_result(dp_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .done(done), .err(err),
        .state_dbg(state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0]       w1, w2, w3, w4;
        logic [7:0]       pix_base, pix_step;
        logic             gap, bp;
        logic [RES_W-1:0] r0, r1, r2, r3;
    } frame_vec_t;

    frame_vec_t       vecs [6];
    logic [RES_W-1:0] exp_q [$];
    int               tests = 0;
    int               fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"},
              {59'd0, pix_ready, dp_kernel_load_valid, res_valid, res_last, busy},
              64'd0);
        check({tag, "_done_err"}, {done, err}, 2'b00);
        check({tag, "_dp"}, {dp_pixel, dp_w1, dp_w2, dp_w3, dp_w4}, 40'd0);
        check({tag, "_res_data"}, res_data, '0);
        check({tag, "_state"}, state_dbg, S_IDLE);
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        pix_valid = 1'b0;
        dp_window_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear without a clock edge.
    task automatic reset_mid(input string tag);
        rst = 1'b0;
        #1;
        check_all_zero(tag);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Driver: runs one frame cycle by cycle; called and returns on a falling edge.
    task automatic run_frame(input frame_vec_t v, input bit no_dp, input bit spur,
                             input bit restart_mid, input int rst_pix,
                             input bit rst_flush, input bit exp_err, input string tag);
        logic [RES_W-1:0] pb [NPIX];
        logic [RES_W-1:0] kw1, kw2, kw3, kw4, pend_d;
        logic [7:0]       exp_pix;
        int               pix_idx, s_idx, cyc, drain_cycles, r, c;
        bit               streaming, seen_done, aborted, pend_v, gap_phase, spur_done, do_rst;

        pix_idx = 0; s_idx = 0; cyc = 0; drain_cycles = 0;
        streaming = 0; seen_done = 0; aborted = 0; pend_v = 0; pend_d = '0;
        gap_phase = 1; spur_done = 0; do_rst = 0;
        kw1 = '0; kw2 = '0; kw3 = '0; kw4 = '0;

        exp_q.delete();
        if (!no_dp) begin
            exp_q.push_back(v.r0);
            exp_q.push_back(v.r1);
            exp_q.push_back(v.r2);
            exp_q.push_back(v.r3);
        end

        start = 1'b1;
        cfg_w1 = v.w1; cfg_w2 = v.w2; cfg_w3 = v.w3; cfg_w4 = v.w4;
        @(negedge clk);
        start = 1'b0;
        cfg_w1 = 8'($urandom_range(0, 255)); cfg_w2 = 8'($urandom_range(0, 255));
        cfg_w3 = 8'($urandom_range(0, 255)); cfg_w4 = 8'($urandom_range(0, 255));
        check({tag, "_start"}, {state_dbg, busy, err}, {S_FILL, 1'b1, 1'b0});

        while (!seen_done && !aborted && cyc < 400) begin
            cyc++;
            if (rst_flush && state_dbg == S_FLUSH) begin
                reset_mid({tag, "_rst_flush"});
                aborted = 1;
            end else begin
                if (state_dbg == S_DRAIN) drain_cycles++;

                start = 1'b0;
                if (restart_mid && state_dbg == S_STREAM && s_idx == 2) begin
                    start = 1'b1;
                    cfg_w1 = 8'hAA; cfg_w2 = 8'h55; cfg_w3 = 8'hFF; cfg_w4 = 8'h11;
                end

                // Datapath model: result appears one cycle after its last window pixel.
                dp_window_valid = pend_v;
                dp_result = pend_d;
                pend_v = 0;
                if (spur && !spur_done && state_dbg == S_FILL && pix_idx == 3) begin
                    dp_window_valid = 1'b1;
                    dp_result = 21'h12345;
                    spur_done = 1;
                end

                if (streaming && s_idx < NPIX) begin
                    exp_pix = 8'(v.pix_base + v.pix_step * 8'(s_idx));
                    check({tag, "_stream_pix"}, {state_dbg, dp_pixel}, {S_STREAM, exp_pix});
                    pb[s_idx] = RES_W'(dp_pixel);
                    r = s_idx / 3;
                    c = s_idx % 3;
                    if (!no_dp && r >= 1 && c >= 1) begin
                        pend_v = 1;
                        pend_d = kw1 * pb[s_idx-4] + kw2 * pb[s_idx-3]
                               + kw3 * pb[s_idx-1] + kw4 * pb[s_idx];
                    end
                    s_idx++;
                    if (rst_pix > 0 && s_idx == rst_pix) do_rst = 1;
                end else if (streaming && s_idx == NPIX) begin
                    check({tag, "_after_stream"}, {state_dbg, dp_pixel}, {S_DRAIN, 8'd0});
                    s_idx++;
                end

                if (dp_kernel_load_valid) begin
                    check({tag, "_kload_w"}, {dp_w1, dp_w2, dp_w3, dp_w4},
                          {v.w1, v.w2, v.w3, v.w4});
                    kw1 = RES_W'(dp_w1); kw2 = RES_W'(dp_w2);
                    kw3 = RES_W'(dp_w3); kw4 = RES_W'(dp_w4);
                    streaming = 1;
                end

                if (do_rst) begin
                    reset_mid({tag, "_rst_stream"});
                    aborted = 1;
                end else begin
                    gap_phase = ~gap_phase;
                    pix_valid = (pix_idx < NPIX) && (!v.gap || gap_phase);
                    pix_data = pix_valid ? 8'(v.pix_base + v.pix_step * 8'(pix_idx))
                                         : 8'($urandom_range(0, 255));
                    if (pix_valid && pix_ready) pix_idx++;

                    // Scoreboard: head must match and stay put until popped.
                    res_ready = v.bp ? (state_dbg == S_FLUSH) : ($urandom_range(0, 3) != 0);
                    if (res_valid) begin
                        if (exp_q.size() == 0) begin
                            check({tag, "_res_extra"}, res_data, '0);
                            check({tag, "_res_extra_valid"}, res_valid, 1'b0);
                        end else begin
                            check({tag, "_res_data"}, res_data, exp_q[0]);
                            check({tag, "_res_last"}, res_last, exp_q.size() == 1);
                            if (res_ready) void'(exp_q.pop_front());
                        end
                    end

                    if (done) begin
                        check({tag, "_done_flush"}, {state_dbg, res_valid}, {S_FLUSH, 1'b0});
                        check({tag, "_done_drained"}, exp_q.size(), 0);
                        seen_done = 1;
                    end
                    @(negedge clk);
                end
            end
        end

        idle_inputs();
        if (aborted) begin
            exp_q.delete();
        end else begin
            check({tag, "_frame_done"}, seen_done, 1'b1);
            check({tag, "_end_idle"}, {state_dbg, busy, done}, {S_IDLE, 1'b0, 1'b0});
            check({tag, "_err"}, err, exp_err);
            check({tag, "_left"}, exp_q.size(), 0);
            check({tag, "_w_hold"}, {dp_w1, dp_w2, dp_w3, dp_w4}, {v.w1, v.w2, v.w3, v.w4});
            if (no_dp) check({tag, "_drain_cycles"}, drain_cycles, 64);
        end
    endtask

    initial begin
        // {w1,w2,w3,w4, pix_base, pix_step, gap, bp, expected results}
        vecs[0] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0,
                    21'd6, 21'd8, 21'd12, 21'd14};
        vecs[1] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 1'b1, 1'b0,
                    21'd6, 21'd8, 21'd12, 21'd14};
        vecs[2] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1,
                    21'd6, 21'd8, 21'd12, 21'd14};
        vecs[3] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1, 1'b0,
                    21'd12, 21'd16, 21'd24, 21'd28};
        vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0,
                    21'd260100, 21'd260100, 21'd260100, 21'd260100};
        vecs[5] = '{8'd2, 8'd0, 8'd0, 8'd3, 8'd10, 8'd10, 1'b0, 1'b1,
                    21'd170, 21'd220, 21'd320, 21'd370};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 0, 0, 0, -1, 0, 0, $sformatf("vec%0d", i));
        end

        run_frame(vecs[0], 1, 0, 0, -1, 0, 1, "timeout");
        run_frame(vecs[0], 0, 0, 0, -1, 0, 0, "after_timeout");

        run_frame(vecs[0], 0, 0, 0, 5, 0, 0, "rst_stream");
        run_frame(vecs[0], 0, 0, 0, -1, 0, 0, "after_rst_stream");

        run_frame(vecs[2], 0, 0, 0, -1, 1, 0, "rst_flush");
        run_frame(vecs[3], 0, 0, 0, -1, 0, 0, "after_rst_flush");

        run_frame(vecs[0], 0, 1, 1, -1, 0, 1, "spurious");
        run_frame(vecs[5], 0, 0, 0, -1, 0, 0, "after_spurious");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_stream_ctrl.md
CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 Parameters SHALL be: dataSize, 8, pixel/weight width; IMG_WIDTH, 3, square image side; TIMEOUT, 64, max DRAIN cycles before error.
REQ-002 Derived constants SHALL be: NPIX = IMG_WIDTH*IMG_WIDTH; NRES = (IMG_WIDTH-1)^2; RES_W = 2*dataSize+5.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin one frame; sampled only in IDLE.
REQ-006 cfg_w1..cfg_w4  in  dataSize each  kernel weights; captured on accepted start.
REQ-007 pix_valid / pix_ready  in / out  1 / 1  upstream pixel handshake, raster order.
REQ-008 pix_data  in  dataSize  upstream pixel.
REQ-009 dp_pixel  out  dataSize  pixel to datapath.
REQ-010 dp_w1..dp_w4  out  dataSize each  registered weights to datapath.
REQ-011 dp_kernel_load_valid  out  1  one-cycle kernel load pulse.
REQ-012 dp_window_valid  in  1  datapath result strobe.
REQ-013 dp_result  in  RES_W  datapath result_k1.
REQ-014 res_valid / res_ready  out / in  1 / 1  downstream result handshake.
REQ-015 res_data  out  RES_W  result word; res_last  out  1  marks the NRES-th result.
REQ-016 busy  out  1  high in every state except IDLE; done  out  1  one-cycle end-of-frame pulse; err  out  1  sticky error.

Function
REQ-017 FSM states SHALL be IDLE, FILL, KLOAD, STREAM, DRAIN, FLUSH.
REQ-018 IDLE -> FILL on start=1; weights latched into dp_w* the same edge.
REQ-019 FILL: pix_ready=1; each pix_valid&pix_ready writes pixel buffer[wr_cnt], wr_cnt++; after NPIX-th transfer -> KLOAD; pix_ready=0 in all other states.
REQ-020 KLOAD: dp_kernel_load_valid=1 for exactly one cycle, then -> STREAM.
REQ-021 STREAM: dp_pixel = buffer[rd_cnt] on NPIX consecutive cycles, no gaps, raster order; after last pixel -> DRAIN; dp_pixel=0 outside STREAM.
REQ-022 In STREAM and DRAIN, each dp_window_valid=1 SHALL push dp_result into a result FIFO of depth NRES and increment res_cnt.
REQ-023 DRAIN -> FLUSH when res_cnt reaches NRES, or when TIMEOUT cycles elapse in DRAIN (sets err).
REQ-024 FLUSH -> IDLE when the FIFO is empty; done=1 on the transition cycle.
REQ-025 res_valid = FIFO not empty; res_data = FIFO head (show-ahead); pop on res_valid&res_ready; data SHALL be held stable while res_valid=1 and res_ready=0.
REQ-026 res_last=1 while the head entry is the NRES-th result of the frame.
REQ-027 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-028 dp_window_valid when res_cnt==NRES, or in IDLE/FILL/KLOAD/FLUSH, SHALL be dropped and set err.
REQ-029 start outside IDLE SHALL be ignored; err is cleared only by reset or by the next accepted start.
REQ-030 Results SHALL be passed unmodified at full RES_W width, with no truncation or saturation.

Reset
REQ-031 While rst=0, asynchronously: state=IDLE; all counters and FIFO pointers=0; pix_ready, dp_kernel_load_valid, res_valid, res_last, busy, done, err=0; dp_pixel, dp_w*, res_data=0.
REQ-032 Reset asserted mid-frame SHALL discard buffered pixels and results; the first frame after release behaves as from power-up.

Verification
REQ-033 Nominal: bench with systolic_datapath attached, IMG_WIDTH=3, weights 1,0,0,1, pixels 1..9 -> results 6,8,12,14 in order, res_last on 14, done pulse, err=0.
REQ-034 Upstream gaps: pix_valid toggles every other cycle during FILL -> dp_pixel still shows 9 gap-free cycles starting the cycle after the KLOAD pulse; same 4 results.
REQ-035 Backpressure: res_ready=0 until FLUSH, then 1 -> 4 results held intact, popped in order, done on the cycle the FIFO empties.
REQ-036 Timeout: force dp_window_valid=0 -> after 64 DRAIN cycles err=1, FLUSH, then IDLE with done pulse.
REQ-037 Reset mid-STREAM: rst=0 at 5th pixel -> all outputs 0 immediately; next frame 1..9 yields 6,8,12,14.
REQ-038 Spurious strobe: dp_window_valid pulse in FILL -> err=1, FIFO unchanged, frame results still 6,8,12,14.
